// File: rtl/solve_arbiter_if.sv
// Bundles the four-requester bus and the solve datapath handshake shared by the arbiter.
// The slave modport is the arbiter; master is the requester/datapath environment around it.
interface solve_arbiter_if;
  logic [3:0]         req;
  logic [31:0]        x_in;
  logic [63:0]        a_in;
  logic [63:0]        b_in;
  logic [63:0]        c_in;
  logic [3:0]         ack;
  logic [3:0]         done;
  logic [3:0]         err;
  logic signed [15:0] y_out;
  logic               busy;
  logic signed [7:0]  solve_x;
  logic signed [15:0] solve_a;
  logic signed [15:0] solve_b;
  logic signed [15:0] solve_c;
  logic               solve_enable;
  logic signed [15:0] solve_y;
  logic               solve_ready;
  logic               solve_valid;

  modport master (
    output req, x_in, a_in, b_in, c_in, solve_y, solve_ready, solve_valid,
    input  ack, done, err, y_out, busy,
           solve_x, solve_a, solve_b, solve_c, solve_enable
  );

  modport slave (
    input  req, x_in, a_in, b_in, c_in, solve_y, solve_ready, solve_valid,
    output ack, done, err, y_out, busy,
           solve_x, solve_a, solve_b, solve_c, solve_enable
  );
endinterface

// File: rtl/solve_arbiter.sv
// Round-robin arbiter that hands one of four requesters' operands to a shared solve datapath
// and returns its result (or a timeout error) to that requester as one-cycle pulses.
module solve_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ENABLE_CYCLES  = 1
) (
  input logic            clock,
  input logic            reset,
  solve_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int EW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [EW-1:0] EN_LAST  = EW'(ENABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_VALID = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         last_grant;
  logic [1:0]         cur;
  logic [1:0]         grant;
  logic               found;
  logic [TW-1:0]      tmo_cnt;
  logic [EW-1:0]      en_cnt;
  logic [3:0]         ack_r;
  logic [3:0]         done_r;
  logic [3:0]         err_r;
  logic signed [15:0] y_r;
  logic               busy_r;
  logic               en_r;
  logic signed [7:0]  sx;
  logic signed [15:0] sa;
  logic signed [15:0] sb;
  logic signed [15:0] sc;

  // Search starts one past the previous winner; the 2-bit add wraps modulo 4.
  always_comb begin
    logic [1:0] idx;
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && bus.req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      cur        <= '0;
      tmo_cnt    <= '0;
      en_cnt     <= '0;
      ack_r      <= '0;
      done_r     <= '0;
      err_r      <= '0;
      y_r        <= '0;
      busy_r     <= 1'b0;
      en_r       <= 1'b0;
      sx         <= '0;
      sa         <= '0;
      sb         <= '0;
      sc         <= '0;
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      err_r  <= '0;
      case (state)
        IDLE: begin
          if (found && bus.solve_ready) begin
            sx         <= bus.x_in[8*grant +: 8];
            sa         <= bus.a_in[16*grant +: 16];
            sb         <= bus.b_in[16*grant +: 16];
            sc         <= bus.c_in[16*grant +: 16];
            cur        <= grant;
            last_grant <= grant;
            ack_r      <= 4'b0001 << grant;
            en_r       <= 1'b1;
            en_cnt     <= EN_LAST;
            busy_r     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (en_cnt == '0) begin
            en_r    <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT_VALID;
          end else begin
            en_cnt <= en_cnt - EW'(1);
          end
        end
        WAIT_VALID: begin
          if (bus.solve_valid) begin
            y_r    <= bus.solve_y;
            done_r <= 4'b0001 << cur;
            state  <= WAIT_READY;
          end else if (tmo_cnt == TMO_LAST) begin
            err_r <= 4'b0001 << cur;
            state <= WAIT_READY;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_READY: begin
          // Operands stay on solve_x/a/b/c until the datapath is idle again.
          if (bus.solve_ready && !bus.solve_valid) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          en_r   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack          = ack_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
  assign bus.y_out        = y_r;
  assign bus.busy         = busy_r;
  assign bus.solve_enable = en_r;
  assign bus.solve_x      = sx;
  assign bus.solve_a      = sa;
  assign bus.solve_b      = sb;
  assign bus.solve_c      = sc;

endmodule

// File: tb/tb_solve_arbiter.sv
// Bench for solve_arbiter: quadratic solve datapath model with programmable latency,
// event monitor, and a round-robin/quadratic reference model fed with randomized jobs.
module tb_solve_arbiter;
  localparam int TMO = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  solve_arbiter_if bus();

  solve_arbiter #(.TIMEOUT_CYCLES(TMO), .ENABLE_CYCLES(1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int op_x [4];
  int op_a [4];
  int op_b [4];
  int op_c [4];
  int ref_last;
  int model_lat = 3;

  logic [3:0]  ack_q[$];
  logic [3:0]  done_q[$];
  logic [3:0]  err_q[$];
  logic [15:0] done_y[$];
  logic [55:0] en_ops[$];
  int          ack_c[$];
  int          done_c[$];
  int          err_c[$];
  int          en_c[$];
  bit          onehot_bad = 1'b0;

  function automatic logic [15:0] quad(input int x, input int a, input int b, input int c);
    int r;
    r = a * x * x + b * x + c;
    return r[15:0];
  endfunction

  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clock); #1;
      if (bus.ack != 4'b0) begin ack_q.push_back(bus.ack); ack_c.push_back(cyc); end
      if (bus.done != 4'b0) begin
        done_q.push_back(bus.done); done_c.push_back(cyc); done_y.push_back(bus.y_out);
      end
      if (bus.err != 4'b0) begin err_q.push_back(bus.err); err_c.push_back(cyc); end
      if (bus.solve_enable) begin
        en_c.push_back(cyc);
        en_ops.push_back({bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c});
      end
      if ($countones(bus.ack) > 1 || $countones(bus.done) > 1 || $countones(bus.err) > 1 ||
          (bus.done != 4'b0 && bus.err != 4'b0))
        onehot_bad = 1'b1;
    end
  end

  // Solve datapath: y = a*x^2 + b*x + c, valid for one cycle model_lat cycles after enable rises.
  int          m_cnt = -1;
  bit          m_prev = 1'b0;
  logic [15:0] m_y = '0;
  initial begin
    bus.solve_valid = 1'b0;
    bus.solve_y     = '0;
    forever begin
      @(posedge clock); #1;
      bus.solve_valid = 1'b0;
      bus.solve_y     = 16'($urandom);
      if (!reset) begin
        m_cnt  = -1;
        m_prev = 1'b0;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.solve_valid = 1'b1;
            bus.solve_y     = m_y;
            m_cnt           = -1;
          end
        end
        if (bus.solve_enable && !m_prev && model_lat > 0) begin
          m_cnt = model_lat;
          m_y   = quad(bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c);
        end
        m_prev = bus.solve_enable;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic clear_mon();
    ack_q.delete(); done_q.delete(); err_q.delete(); done_y.delete(); en_ops.delete();
    ack_c.delete(); done_c.delete(); err_c.delete(); en_c.delete();
  endtask

  task automatic set_ops(input int i, input int x, input int a, input int b, input int c);
    op_x[i] = x; op_a[i] = a; op_b[i] = b; op_c[i] = c;
    bus.x_in[8*i +: 8]  = x[7:0];
    bus.a_in[16*i +: 16] = a[15:0];
    bus.b_in[16*i +: 16] = b[15:0];
    bus.c_in[16*i +: 16] = c[15:0];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req = 4'b0;
    bus.solve_ready = 1'b1;
    model_lat = 3;
    repeat (3) step();
    clear_mon();
    ref_last = 3;
    reset = 1'b1;
  endtask

  task automatic run_job(input int budget, input bit drop, output bit ok);
    int ends0;
    ends0 = done_q.size() + err_q.size();
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (drop && bus.ack != 4'b0) bus.req = 4'b0;
      if (done_q.size() + err_q.size() > ends0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = 4'b1111;
    bus.solve_ready = 1'b1;
    repeat (2) step();
    vectors++; if (bus.ack !== 4'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    vectors++; if (bus.done !== 4'b0 || bus.err !== 4'b0) begin miscompares++; $display("FAIL reset_done_err got %b/%b want 0000/0000", bus.done, bus.err); end
    vectors++; if (bus.busy !== 1'b0 || bus.solve_enable !== 1'b0) begin miscompares++; $display("FAIL reset_busy_en got %b/%b want 0/0", bus.busy, bus.solve_enable); end
    vectors++; if (bus.y_out !== 16'h0) begin miscompares++; $display("FAIL reset_y got %h want 0000", bus.y_out); end
    vectors++; if ({bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c} !== 56'h0) begin miscompares++; $display("FAIL reset_ops got %h want 0", {bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c}); end
  endtask

  task automatic test_single_job();
    bit ok;
    int c0;
    logic [55:0] want_ops;
    do_reset();
    want_ops = {8'd2, 16'd3, 16'd4, 16'd5};
    set_ops(1, 2, 3, 4, 5);
    bus.req = 4'b0010;
    c0 = cyc;
    run_job(100, 1'b1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_complete got %b want 1", ok); end
    vectors++; if (ack_q.size() != 1 || ack_q[0] !== 4'b0010) begin miscompares++; $display("FAIL single_ack count %0d first %b want 1 x 0010", ack_q.size(), ack_q[0]); end
    vectors++; if (ack_c[0] != c0 + 1) begin miscompares++; $display("FAIL single_ack_latency got cycle %0d want %0d", ack_c[0], c0 + 1); end
    vectors++; if (en_c.size() != 1 || en_c[0] != ack_c[0]) begin miscompares++; $display("FAIL single_enable count %0d cycle %0d want 1 at %0d", en_c.size(), en_c[0], ack_c[0]); end
    vectors++; if (en_ops[0] !== want_ops) begin miscompares++; $display("FAIL single_operands got %h want %h", en_ops[0], want_ops); end
    vectors++; if (done_q.size() != 1 || done_q[0] !== 4'b0010) begin miscompares++; $display("FAIL single_done count %0d first %b want 1 x 0010", done_q.size(), done_q[0]); end
    vectors++; if (done_y[0] !== 16'd25) begin miscompares++; $display("FAIL single_y got %0d want 25", $signed(done_y[0])); end
    vectors++; if (done_c[0] - en_c[0] != 4) begin miscompares++; $display("FAIL single_done_latency got %0d want 4", done_c[0] - en_c[0]); end
    vectors++; if (err_q.size() != 0) begin miscompares++; $display("FAIL single_no_err got %0d want 0", err_q.size()); end
  endtask

  task automatic test_signed_job();
    bit ok;
    logic [55:0] want_ops;
    do_reset();
    want_ops = {8'hFD, 16'hFFFF, 16'd2, 16'd7};
    set_ops(0, -3, -1, 2, 7);
    bus.req = 4'b0001;
    run_job(100, 1'b1, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL signed_complete got %b want 1", ok); end
    vectors++; if (en_ops[0] !== want_ops) begin miscompares++; $display("FAIL signed_operands got %h want %h", en_ops[0], want_ops); end
    vectors++; if (done_q[0] !== 4'b0001 || done_y[0] !== 16'hFFF8) begin miscompares++; $display("FAIL signed_y got %b/%h want 0001/fff8", done_q[0], done_y[0]); end
    vectors++; if (bus.y_out !== 16'hFFF8) begin miscompares++; $display("FAIL signed_y_hold got %h want fff8", bus.y_out); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g;
    logic [3:0] want;
    do_reset();
    model_lat = 1;
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, 1, 0, 0);
    bus.req = 4'b1111;
    for (int n = 0; n < 300 && ack_q.size() < 5; n++) step();
    bus.req = 4'b0;
    run_job(100, 1'b0, ok);
    vectors++; if (ok !== 1'b1 || ack_q.size() != 5) begin miscompares++; $display("FAIL rr_count got %0d acks (drained %b) want 5", ack_q.size(), ok); end
    for (int k = 0; k < 5; k++) begin
      g = ref_pick(4'b1111, ref_last);
      ref_last = g;
      want = 4'b0001 << g;
      vectors++; if (ack_q[k] !== want || done_q[k] !== want) begin miscompares++; $display("FAIL rr_order[%0d] got ack %b done %b want %b", k, ack_q[k], done_q[k], want); end
      vectors++; if (done_y[k] !== quad(op_x[g], op_a[g], op_b[g], op_c[g])) begin miscompares++; $display("FAIL rr_y[%0d] got %h want %h", k, done_y[k], quad(op_x[g], op_a[g], op_b[g], op_c[g])); end
    end
  endtask

  task automatic test_ready_gating();
    bit ok;
    int r;
    do_reset();
    set_ops(2, 1, 1, 1, 1);
    bus.solve_ready = 1'b0;
    bus.req = 4'b0100;
    repeat (10) step();
    vectors++; if (ack_q.size() != 0 || en_c.size() != 0) begin miscompares++; $display("FAIL gate_hold got %0d acks %0d enables want 0/0", ack_q.size(), en_c.size()); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL gate_busy got %b want 0", bus.busy); end
    bus.solve_ready = 1'b1;
    r = cyc;
    run_job(100, 1'b1, ok);
    vectors++; if (ok !== 1'b1 || ack_q[0] !== 4'b0100) begin miscompares++; $display("FAIL gate_ack got %b (done %b) want 0100", ack_q[0], ok); end
    vectors++; if (ack_c[0] != r + 1) begin miscompares++; $display("FAIL gate_latency got cycle %0d want %0d", ack_c[0], r + 1); end
    vectors++; if (done_q[0] !== 4'b0100 || done_y[0] !== 16'd3) begin miscompares++; $display("FAIL gate_done got %b/%h want 0100/0003", done_q[0], done_y[0]); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    do_reset();
    model_lat = 2;
    set_ops(0, 2, 3, 4, 5);
    bus.req = 4'b0001;
    run_job(100, 1'b1, ok);
    vectors++; if (ok !== 1'b1 || bus.y_out !== 16'd25) begin miscompares++; $display("FAIL tmo_setup got y %h (done %b) want 0019", bus.y_out, ok); end
    clear_mon();
    model_lat = -1;
    set_ops(3, 9, 9, 9, 9);
    bus.req = 4'b1000;
    seen = 1'b0;
    for (int n = 0; n < TMO + 40 && !seen; n++) begin
      step();
      if (bus.ack != 4'b0) bus.req = 4'b0;
      if (err_q.size() > 0) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b1 || err_q[0] !== 4'b1000) begin miscompares++; $display("FAIL tmo_err got %b (seen %b) want 1000", err_q[0], seen); end
    vectors++; if (err_c[0] - en_c[0] != TMO + 1) begin miscompares++; $display("FAIL tmo_latency got %0d want %0d", err_c[0] - en_c[0], TMO + 1); end
    vectors++; if (done_q.size() != 0 || bus.y_out !== 16'd25) begin miscompares++; $display("FAIL tmo_y got %0d dones y %h want 0/0019", done_q.size(), bus.y_out); end
    bus.solve_ready = 1'b0;
    repeat (5) step();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL tmo_wait_ready got busy %b want 1", bus.busy); end
    bus.solve_ready = 1'b1;
    step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL tmo_release got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    do_reset();
    model_lat = -1;
    set_ops(1, 5, 5, 5, 5);
    bus.req = 4'b0010;
    repeat (12) begin
      step();
      if (bus.ack != 4'b0) bus.req = 4'b0;
    end
    vectors++; if (bus.busy !== 1'b1 || bus.solve_x !== 8'd5) begin miscompares++; $display("FAIL midrst_setup got busy %b x %h want 1/05", bus.busy, bus.solve_x); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.solve_enable !== 1'b0 || bus.ack !== 4'b0 || bus.done !== 4'b0 || bus.err !== 4'b0) begin miscompares++; $display("FAIL midrst_async got busy %b en %b ack %b done %b err %b want all 0", bus.busy, bus.solve_enable, bus.ack, bus.done, bus.err); end
    vectors++; if ({bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c, bus.y_out} !== 72'h0) begin miscompares++; $display("FAIL midrst_data got %h want 0", {bus.solve_x, bus.solve_a, bus.solve_b, bus.solve_c, bus.y_out}); end
    step();
    step();
    clear_mon();
    reset = 1'b1;
    model_lat = 3;
    set_ops(2, -7, 100, -3, 11);
    bus.req = 4'b0100;
    run_job(100, 1'b1, ok);
    vectors++; if (ok !== 1'b1 || ack_q[0] !== 4'b0100) begin miscompares++; $display("FAIL midrst_regrant got %b (done %b) want 0100", ack_q[0], ok); end
    vectors++; if (done_q.size() != 1 || done_q[0] !== 4'b0100 || err_q.size() != 0) begin miscompares++; $display("FAIL midrst_stale got %0d dones %0d errs want 1/0", done_q.size(), err_q.size()); end
    vectors++; if (done_y[0] !== quad(-7, 100, -3, 11)) begin miscompares++; $display("FAIL midrst_y got %h want %h", done_y[0], quad(-7, 100, -3, 11)); end
  endtask

  task automatic test_random();
    bit ok;
    bit tmo_job;
    int g;
    logic [3:0] rq;
    logic [3:0] want;
    logic [15:0] ref_y;
    logic [15:0] ey;
    do_reset();
    ref_y = '0;
    onehot_bad = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++)
        set_ops(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      rq = 4'($urandom_range(1, 15));
      tmo_job = ($urandom_range(0, 7) == 0);
      model_lat = tmo_job ? -1 : int'($urandom_range(1, 6));
      bus.solve_ready = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      bus.solve_ready = 1'b1;
      clear_mon();
      g = ref_pick(rq, ref_last);
      want = 4'b0001 << g;
      bus.req = rq;
      run_job(TMO + 40, 1'b1, ok);
      vectors++; if (ok !== 1'b1 || ack_q.size() != 1 || ack_q[0] !== want) begin miscompares++; $display("FAIL rand[%0d]_ack req %b got %b (n=%0d done %b) want %b", r, rq, ack_q[0], ack_q.size(), ok, want); end
      if (tmo_job) begin
        vectors++; if (err_q.size() != 1 || err_q[0] !== want || done_q.size() != 0 || bus.y_out !== ref_y) begin miscompares++; $display("FAIL rand[%0d]_tmo got err %b dones %0d y %h want %b/0/%h", r, err_q[0], done_q.size(), bus.y_out, want, ref_y); end
      end else begin
        ey = quad(op_x[g], op_a[g], op_b[g], op_c[g]);
        vectors++; if (done_q.size() != 1 || done_q[0] !== want || done_y[0] !== ey || err_q.size() != 0) begin miscompares++; $display("FAIL rand[%0d]_done got %b y %h errs %0d want %b y %h", r, done_q[0], done_y[0], err_q.size(), want, ey); end
        ref_y = ey;
      end
      ref_last = g;
    end
    vectors++; if (onehot_bad !== 1'b0) begin miscompares++; $display("FAIL onehot got overlapping ack/done/err pulses want none"); end
  endtask

  initial begin
    bus.req = 4'b0;
    bus.x_in = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.c_in = '0;
    bus.solve_ready = 1'b1;
    test_reset();
    test_single_job();
    test_signed_job();
    test_round_robin();
    test_ready_gating();
    test_timeout();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/solve_arbiter.md
SOLVE_ARBITER -- requirements
Module: solve_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: cycles waited in WAIT_VALID before abandoning a job.
REQ-002 Parameter ENABLE_CYCLES, default 1: cycles solve_enable is held high per job (1..4).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  per-requester level request, one bit per requester 0..3.
REQ-007 x_in  input  32  four signed 8-bit x operands; requester i at [8i+7:8i].
REQ-008 a_in, b_in, c_in  input  64 each  four signed 16-bit coefficients; requester i at [16i+15:16i].
REQ-009 ack  output  4  one-hot, one-cycle pulse: request i accepted and operands latched.
REQ-010 done  output  4  one-hot, one-cycle pulse: result for requester i on y_out.
REQ-011 err  output  4  one-hot, one-cycle pulse: job for requester i timed out.
REQ-012 y_out  output  16  signed result; holds last captured value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 solve_x  output  8  signed; solve_a, solve_b, solve_c  output  16 each  signed; operands to the solve datapath.
REQ-015 solve_enable  output  1  start strobe to solve.
REQ-016 solve_y  input  16  signed; solve_ready  input  1; solve_valid  input  1; solve datapath outputs.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_VALID, WAIT_READY.
REQ-018 IDLE: req is sampled only here; if any req bit and solve_ready are high, grant the first set bit searching from (last_grant+1) mod 4 upward, wrapping; otherwise stay in IDLE.
REQ-019 On a grant edge the block SHALL: latch the granted operands into solve_x/a/b/c; record the grant index; update last_grant; assert ack[g] for the next cycle; enter ISSUE.
REQ-020 ISSUE: solve_enable high for exactly ENABLE_CYCLES cycles, then enter WAIT_VALID; the timeout counter clears on entry to WAIT_VALID.
REQ-021 solve_x/a/b/c SHALL remain stable from the grant edge until WAIT_READY is exited.
REQ-022 WAIT_VALID: on the first edge sampling solve_valid=1, capture solve_y into y_out, pulse done[g] for one cycle, enter WAIT_READY.
REQ-023 WAIT_VALID timeout: after TIMEOUT_CYCLES edges without solve_valid, pulse err[g], leave y_out unchanged, enter WAIT_READY.
REQ-024 WAIT_READY: enter IDLE on the first edge sampling solve_ready=1 and solve_valid=0.
REQ-025 Minimum latency SHALL be: req high in IDLE -> ack next cycle -> solve_enable in that same cycle -> done one cycle after solve_valid is sampled.
REQ-026 req bits SHALL be ignored outside IDLE; a req still high at return to IDLE is a new request.
REQ-027 At most one bit of ack, done or err SHALL be high in any cycle; done and err for the same job are mutually exclusive.
REQ-028 Requests SHALL NOT be granted while solve_ready=0; the request waits and is not dropped.
REQ-029 Arithmetic SHALL be pass-through; no width conversion is performed on operands or result.

Reset
REQ-030 reset=0 SHALL force, asynchronously, state IDLE and last_grant=3 (requester 0 has first priority).
REQ-031 reset=0 SHALL clear ack, done, err, busy, solve_enable, y_out, solve_x/a/b/c and the timeout counter to 0.
REQ-032 reset asserted mid-job SHALL abandon the job with no done or err pulse; solve_enable drops immediately.

Verification
REQ-033 Single job: req=0010, x=2, a=3, b=4, c=5, model valid 3 cycles after enable -> ack=0010 one cycle, solve_enable one cycle with operands 2/3/4/5, done=0010 with y_out=25.
REQ-034 Signed job: req=0001, x=-3, a=-1, b=2, c=7 -> done=0001, y_out=-8 (0xFFF8).
REQ-035 Round-robin: req=1111 held from reset release -> grants in order 0,1,2,3,0; each requester receives exactly one ack per rotation.
REQ-036 Ready gating: solve_ready=0 for 10 cycles with req=0100 -> no ack and no solve_enable; ack=0100 one cycle after solve_ready rises.
REQ-037 Timeout: model never asserts valid, req=1000 -> err=1000 after 64 WAIT_VALID cycles, no done, y_out unchanged, return to IDLE once ready=1.
REQ-038 Reset mid-job: reset=0 in WAIT_VALID -> all outputs 0 the same cycle; after release, req=0100 is granted normally with no stale done.
